// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, command constants and helpers
// Used by ps2_host_tx (and any PS/2 receiver built alongside it).
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, PARITY, ACK, WAIT_IDLE} ps2_state_e;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer plus falling-edge detect for one PS/2 line
// Ports: i_cpu_clk/i_rstn_sync_cpu clock and async active-low reset,
//        line raw async input, sync synchronized level, fe one-cycle falling-edge pulse.
module ps2_line_sync (
  input  logic i_cpu_clk,
  input  logic i_rstn_sync_cpu,
  input  logic line,
  output logic sync,
  output logic fe
);
  // sh[1:0] is the synchronizer, sh[2] the previous synced level; idle bus is high
  logic [2:0] sh;
  always_ff @(posedge i_cpu_clk or negedge i_rstn_sync_cpu)
    if (!i_rstn_sync_cpu) sh <= '1;
    else sh <= {sh[1:0], line};
  assign sync = sh[1];
  assign fe   = sh[2] & ~sh[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter
// Ports: i_cpu_clk/i_rstn_sync_cpu clock and async active-low reset;
//        i_ps2_clk/i_ps2_data raw bus lines; i_tx_valid/i_tx_byte/o_tx_ready byte handshake;
//        o_ps2_txclk/o_ps2_txdata open-drain values (0) with enables o_ps2_txclk_e/o_ps2_txdata_e;
//        o_done end-of-frame pulse, o_ack_ok device ACK result, o_timeout abort pulse.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 180,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic       i_cpu_clk,
  input  logic       i_rstn_sync_cpu,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_ps2_txclk,
  output logic       o_ps2_txdata,
  output logic       o_ps2_txclk_e,
  output logic       o_ps2_txdata_e,
  output logic       o_done,
  output logic       o_ack_ok,
  output logic       o_timeout
);
  localparam int W = $clog2(max2(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [W-1:0] INH_LAST = W'(INHIBIT_CYCLES - 1);
  localparam logic [W-1:0] TMO_LAST = W'(TIMEOUT_CYCLES - 1);

  ps2_state_e state, state_n;
  logic [W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic par, par_n, clk_e_n, data_e_n, done_n, tout_n, ack_n;
  logic clk_s, clk_fe, data_s, data_fe_unused;
  logic accept, timed, fin, tmo;

  ps2_line_sync u_clk_sync (
    .i_cpu_clk      (i_cpu_clk),
    .i_rstn_sync_cpu(i_rstn_sync_cpu),
    .line           (i_ps2_clk),
    .sync           (clk_s),
    .fe             (clk_fe)
  );

  ps2_line_sync u_data_sync (
    .i_cpu_clk      (i_cpu_clk),
    .i_rstn_sync_cpu(i_rstn_sync_cpu),
    .line           (i_ps2_data),
    .sync           (data_s),
    .fe             (data_fe_unused)
  );

  assign o_ps2_txclk  = 1'b0;
  assign o_ps2_txdata = 1'b0;
  // ready is held off during the o_done cycle so a new accept lands one cycle after it
  assign o_tx_ready = (state == IDLE) && !o_done;
  assign accept     = i_tx_valid && o_tx_ready;
  assign timed      = state inside {DATA, PARITY, ACK, WAIT_IDLE};
  assign fin        = (state == WAIT_IDLE) && clk_s && data_s;
  // a device clock edge restarts the count, so it can never coincide with a timeout
  assign tmo        = timed && !fin && !clk_fe && (cnt == TMO_LAST);
  assign cnt_inc    = (&cnt) ? cnt : cnt + W'(1);

  always_ff @(posedge i_cpu_clk or negedge i_rstn_sync_cpu)
    if (!i_rstn_sync_cpu) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      sh             <= '0;
      par            <= 1'b0;
      o_ps2_txclk_e  <= 1'b0;
      o_ps2_txdata_e <= 1'b0;
      o_done         <= 1'b0;
      o_timeout      <= 1'b0;
      o_ack_ok       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      idx            <= idx_n;
      sh             <= sh_n;
      par            <= par_n;
      o_ps2_txclk_e  <= clk_e_n;
      o_ps2_txdata_e <= data_e_n;
      o_done         <= done_n;
      o_timeout      <= tout_n;
      o_ack_ok       <= ack_n;
    end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = accept ? INHIBIT : IDLE;
      INHIBIT:   state_n = (cnt == INH_LAST) ? REQ : INHIBIT;
      REQ:       state_n = DATA;
      DATA:      state_n = tmo ? IDLE : (clk_fe && idx == 4'd8) ? PARITY : DATA;
      PARITY:    state_n = tmo ? IDLE : clk_fe ? ACK : PARITY;
      ACK:       state_n = tmo ? IDLE : clk_fe ? WAIT_IDLE : ACK;
      WAIT_IDLE: state_n = (fin || tmo) ? IDLE : WAIT_IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // next values for the registered line enables and the datapath
  always_comb begin
    clk_e_n  = accept || (state == INHIBIT);
    data_e_n = (state == IDLE || tmo) ? 1'b0 :
               (state == INHIBIT) ? (cnt == INH_LAST) :
               (state == DATA && clk_fe) ? (idx[3] ? ~par : ~sh[idx[2:0]]) :
               (state == PARITY && clk_fe) ? 1'b0 : o_ps2_txdata_e;
    cnt_n    = (state == INHIBIT || (timed && !clk_fe)) ? cnt_inc : '0;
    idx_n    = (state == REQ) ? 4'd0 : (state == DATA && clk_fe && !idx[3]) ? idx + 4'd1 : idx;
    sh_n     = accept ? i_tx_byte : sh;
    par_n    = accept ? ~^i_tx_byte : par;
    ack_n    = (accept || tmo) ? 1'b0 : (state == ACK && clk_fe) ? ~data_s : o_ack_ok;
    done_n   = fin || tmo;
    tout_n   = tmo;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and randomized frames against a PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 180;
  localparam int TO  = 27000;
  localparam int HP  = 72;

  logic clk = 1'b0, rstn = 1'b1, dev_clk = 1'b1, dev_data = 1'b1, tx_valid = 1'b0, scramble = 1'b0;
  logic [7:0] drv_byte = 8'h00, scr_byte = 8'h00, tx_byte;
  logic tx_ready, txclk, txdata, txclk_e, txdata_e, done, ack_ok, timeout;
  logic ps2_clk, ps2_data;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  logic [7:0] acc_q[$];

  assign tx_byte  = scramble ? scr_byte : drv_byte;
  assign ps2_clk  = txclk_e ? txclk : dev_clk;
  assign ps2_data = txdata_e ? txdata : dev_data;

  ps2_host_tx dut (
    .i_cpu_clk      (clk),
    .i_rstn_sync_cpu(rstn),
    .i_ps2_clk      (ps2_clk),
    .i_ps2_data     (ps2_data),
    .i_tx_valid     (tx_valid),
    .i_tx_byte      (tx_byte),
    .o_tx_ready     (tx_ready),
    .o_ps2_txclk    (txclk),
    .o_ps2_txdata   (txdata),
    .o_ps2_txclk_e  (txclk_e),
    .o_ps2_txdata_e (txdata_e),
    .o_done         (done),
    .o_ack_ok       (ack_ok),
    .o_timeout      (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt++;
  always @(posedge clk) if (scramble) begin #3; scr_byte = 8'($urandom); end
  always @(negedge clk) begin #4; if (tx_valid && tx_ready) acc_q.push_back(tx_byte); end

  initial begin
    #3_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit exp_ack, input bit exp_tmo, input int bound, output int t);
    int n = 0;
    while (!done && n < bound) begin @(negedge clk); n++; end
    t = cyc;
    chk("done_seen", int'(done), 1);
    if (done) begin
      chk("ack_ok", int'(ack_ok), int'(exp_ack));
      chk("timeout", int'(timeout), int'(exp_tmo));
      chk("ready_in_done", int'(tx_ready), 0);
      chk("lines_released", int'({txclk_e, txdata_e}), 0);
      @(negedge clk);
      chk("ready_after_done", int'(tx_ready), 1);
      chk("done_one_cycle", int'(done), 0);
    end
  endtask

  // Device model: waits for the request-to-send, clocks nclk bits at 12.5 kHz,
  // samples the line while clock is high and ACKs on the 11th clock.
  task automatic run_frame(input logic [7:0] b, input bit hold, input bit dev_ack, input int nclk, input bit abort);
    logic [7:0] e;
    logic [9:0] exp_v, seen, mask;
    int inh = 0, req = 0, n = 0, ones = 0, last_fall = 0, t = 0;
    chk("ready_pre", int'(tx_ready), 1);
    if (!hold) begin
      tx_valid = 1'b1; drv_byte = b;
      @(negedge clk);
      tx_valid = 1'b0; drv_byte = 8'($urandom);
    end else @(negedge clk);
    chk("accept_count", acc_q.size(), 1);
    e = (acc_q.size() > 0) ? acc_q.pop_front() : b;
    if (!hold) chk("accepted_byte", int'(e), int'(b));
    chk("ack_cleared", int'(ack_ok), 0);
    for (int i = 0; i < 8; i++) ones += int'(e[i]);
    exp_v = {1'b1, (ones % 2 == 0), e};
    while (n < 1000 && txclk_e) begin
      if (txdata_e) req++; else inh++;
      @(negedge clk); n++;
    end
    chk("inhibit_cycles", inh, INH);
    chk("req_cycles", req, 1);
    chk("data_entry", int'({txclk_e, txdata_e}), 1);
    chk("drive_values", int'({txclk, txdata}), 0);
    repeat (10) @(negedge clk);
    chk("start_bit", int'(ps2_data), 0);
    seen = '0;
    for (int i = 1; i <= nclk; i++) begin
      dev_clk = 1'b0; last_fall = cyc;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
      if (i == 11) dev_data = 1'b1;
      else begin
        repeat (HP) @(negedge clk);
        seen[i-1] = ps2_data;
        if (i == 10) begin dev_data = dev_ack; repeat (5) @(negedge clk); end
      end
    end
    dev_clk = 1'b1; dev_data = 1'b1;
    mask = (nclk >= 10) ? 10'h3FF : 10'((1 << nclk) - 1);
    chk("frame_bits", int'(seen & mask), int'(exp_v & mask));
    if (nclk == 11) wait_done(!dev_ack, 1'b0, 40, t);
    else if (!abort) begin
      wait_done(1'b0, 1'b1, TO + 100, t);
      chk("timeout_latency", int'((t - last_fall) >= TO && (t - last_fall) <= TO + 4), 1);
    end
  endtask

  initial begin
    int pre;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_enables", int'({txclk_e, txdata_e}), 0);
    chk("rst_flags", int'({done, ack_ok, timeout}), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(CMD_SET_LED, 1'b0, 1'b0, 11, 1'b0);
    run_frame(8'h01, 1'b0, 1'b0, 11, 1'b0);
    run_frame(CMD_RESET, 1'b0, 1'b1, 11, 1'b0);
    run_frame(CMD_ENABLE, 1'b0, 1'b0, 4, 1'b0);
    run_frame(CMD_ENABLE, 1'b0, 1'b0, 9, 1'b1);
    chk("parity_drive", int'({txclk_e, txdata_e}), 1);
    pre = done_cnt;
    rstn = 1'b0;
    #1;
    chk("async_release", int'({txclk_e, txdata_e}), 0);
    chk("rst_no_done", int'(done), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_pulse", done_cnt, pre);
    chk("post_rst_ready", int'(tx_ready), 1);
    run_frame(CMD_ENABLE, 1'b0, 1'b0, 11, 1'b0);
    repeat (3) run_frame(8'($urandom), 1'b0, 1'($urandom), 11, 1'b0);
    pre = done_cnt;
    scramble = 1'b1; tx_valid = 1'b1;
    repeat (3) run_frame(8'h00, 1'b1, 1'b0, 11, 1'b0);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    scramble = 1'b0;
    chk("hold_done_count", done_cnt - pre, 3);
    chk("hold_no_extra", acc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 180, meaning the clock-inhibit hold in i_cpu_clk cycles (at least 100 us).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 27000, meaning the maximum i_cpu_clk cycles allowed between device clock falling edges.
REQ-003 i_cpu_clk  input  1  block clock; all logic on its rising edge.
REQ-004 i_rstn_sync_cpu  input  1  reset, asynchronous, active-low; clock i_cpu_clk.
REQ-005 i_ps2_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-006 i_ps2_data  input  1  raw PS/2 data line, asynchronous.
REQ-007 i_tx_valid  input  1  command byte request.
REQ-008 i_tx_byte  input  8  command byte, e.g. 0xED, 0xF4, 0xFF.
REQ-009 o_tx_ready  output  1  high only in IDLE; a byte is accepted when i_tx_valid and o_tx_ready are both high.
REQ-010 o_ps2_txclk, o_ps2_txdata  output  1 each  constant 0; open-drain drive values.
REQ-011 o_ps2_txclk_e, o_ps2_txdata_e  output  1 each  high means pull the line low; low means release the line.
REQ-012 o_done  output  1  one-cycle pulse at the end of every accepted frame.
REQ-013 o_ack_ok  output  1  valid with o_done and held until the next accept: 1 means the device ACK bit was 0.
REQ-014 o_timeout  output  1  one-cycle pulse, coincident with o_done, when the frame was aborted.

Function
REQ-015 i_ps2_clk and i_ps2_data SHALL each pass through a 2-FF synchronizer; a falling edge (fe) SHALL be one cycle when the synced clock is 1 and then 0.
REQ-016 On accept, SHALL latch i_tx_byte, compute odd parity (parity = ~^byte), clear o_ack_ok, and enter INHIBIT.
REQ-017 INHIBIT: clk_e=1, data_e=0 for exactly INHIBIT_CYCLES cycles, then enter REQ.
REQ-018 REQ: clk_e=1 and data_e=1 (start bit) for 1 cycle, then enter DATA with clk_e=0 and data_e=1 held.
REQ-019 DATA: on each fe, SHALL drive bit[idx] LSB first (data_e = ~bit); after idx 7, the next fe enters PARITY.
REQ-020 PARITY: the fe that enters PARITY SHALL drive the parity bit; the next fe SHALL release data (stop bit) and enter ACK.
REQ-021 ACK: on the next fe, SHALL sample synced data; o_ack_ok = ~data; then enter WAIT_IDLE.
REQ-022 WAIT_IDLE: when synced clock and data are both 1, SHALL pulse o_done and enter IDLE; o_tx_ready SHALL rise the following cycle.
REQ-023 The timeout counter SHALL reset on entry to DATA and on every fe; on reaching TIMEOUT_CYCLES in DATA/PARITY/ACK/WAIT_IDLE it SHALL release both lines, pulse o_done and o_timeout with o_ack_ok=0, and enter IDLE.
REQ-024 i_tx_valid outside IDLE SHALL be ignored; i_tx_byte SHALL NOT affect an in-flight frame.
REQ-025 Counters SHALL be sized $clog2(max(INHIBIT_CYCLES,TIMEOUT_CYCLES)+1) and SHALL saturate, never wrap.
REQ-026 Both _e outputs SHALL be registered (glitch-free); at most one of the two is released in the same cycle as the REQ->DATA transition.

Reset
REQ-027 On reset: state IDLE, o_ps2_txclk_e=0, o_ps2_txdata_e=0, o_tx_ready=1, o_done=0, o_ack_ok=0, o_timeout=0, synchronizers=1, counters=0.
REQ-028 Reset asserted mid-frame SHALL release both lines immediately (asynchronously) and SHALL NOT pulse o_done.

Structure
REQ-029 Package ps2_pkg SHALL hold the state encoding (IDLE, INHIBIT, REQ, DATA, PARITY, ACK, WAIT_IDLE) and command constants (CMD_SET_LED=0xED, CMD_ENABLE=0xF4, CMD_RESET=0xFF, RSP_ACK=0xFA).
REQ-030 Sub-module ps2_line_sync (2-FF sync + fe detect) SHALL be instantiated for the clock/data lines and be reusable by the PS/2 receiver.

Verification
REQ-031 Send 0xED, device model clocks at 12.5 kHz and ACKs -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1; o_done with o_ack_ok=1.
REQ-032 Send 0x01 -> parity bit 0; clock held low for 180 cycles before data is pulled low.
REQ-033 Send 0xFF, device returns ACK=1 -> o_done pulse, o_ack_ok=0, o_timeout=0.
REQ-034 Send 0xF4, device stops clocking after bit 3 -> o_timeout and o_done 27000 cycles after the last fe; both _e=0; o_tx_ready=1 next cycle.
REQ-035 Assert reset during PARITY -> both _e=0 the same cycle, no o_done; a following 0xF4 transfers correctly.
REQ-036 Hold i_tx_valid high continuously with changing i_tx_byte -> exactly one byte accepted per frame, each re-accept one cycle after o_done.
